// File: rtl/jtcontra_romrq.sv
// Two-entry read cache in front of the SDRAM controller for a gfx ROM port.
// Hits answer in the same cycle; misses issue one SDRAM read and fill an entry.
module jtcontra_romrq #(
    parameter int          AW     = 18,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    output logic [15:0]   dout,
    output logic          data_ok,
    output logic          sdram_req,
    output logic [21:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [15:0]   sdram_din
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state;
    logic [1:0]    valid;
    logic [AW-1:0] tag      [2];
    logic [15:0]   mem_data [2];
    logic          ptr;
    logic          discard;
    logic [AW-1:0] req_addr;
    logic          hit0, hit1, hit, fill;

    assign hit0    = valid[0] && (tag[0] == addr);
    assign hit1    = valid[1] && (tag[1] == addr);
    assign hit     = hit0 || hit1;
    assign data_ok = cs && hit;
    assign dout    = (!hit0 && hit1) ? mem_data[1] : mem_data[0];

    // A clr during the fill, or at any earlier point of this transaction, drops the returned word
    assign fill = (state == WAIT) && data_rdy && !clr && !discard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= 22'h0;
            valid      <= 2'b00;
            ptr        <= 1'b0;
            discard    <= 1'b0;
            req_addr   <= '0;
        end else begin
            if (clr) begin
                valid <= 2'b00;
                ptr   <= 1'b0;
            end else if (fill) begin
                valid[ptr]    <= 1'b1;
                tag[ptr]      <= req_addr;
                mem_data[ptr] <= sdram_din;
                ptr           <= ~ptr;
            end

            if (state == WAIT && data_rdy)
                discard <= 1'b0;
            else if (clr && state != IDLE)
                discard <= 1'b1;

            case (state)
                IDLE: if (cs && !hit && !clr) begin
                    req_addr   <= addr;
                    sdram_addr <= OFFSET + 22'(addr);
                    sdram_req  <= 1'b1;
                    state      <= REQ;
                end
                REQ: if (sdram_ack) begin
                    sdram_req <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (data_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcontra_romrq.sv
// Directed bench for jtcontra_romrq: cold miss, hit, replacement, addr change
// mid-fill, clr racing data_rdy, reset mid-transaction, clr beating a miss.
module tb_jtcontra_romrq;
    localparam logic [21:0] OFF = 22'h10000;

    logic        clk = 1'b0;
    logic        rst, clr, cs, sdram_ack, data_rdy;
    logic [17:0] addr;
    logic [15:0] sdram_din, dout;
    logic        data_ok, sdram_req;
    logic [21:0] sdram_addr;
    int          n_cmp = 0;
    int          n_err = 0;

    jtcontra_romrq #(.AW(18), .OFFSET(OFF)) dut (
        .clk(clk), .rst(rst), .clr(clr), .addr(addr), .cs(cs),
        .dout(dout), .data_ok(data_ok), .sdram_req(sdram_req),
        .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .sdram_din(sdram_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full miss on address a, returning d; leaves cs high on a.
    task automatic fill(input logic [17:0] a, input logic [15:0] d);
        cs = 1'b1; addr = a; #1;
        chk("fill_miss", 32'(data_ok), 32'd0);
        tick;
        chk("fill_req", 32'(sdram_req), 32'd1);
        chk("fill_addr", 32'(sdram_addr), 32'(OFF + 22'(a)));
        sdram_ack = 1'b1; tick; sdram_ack = 1'b0; #1;
        chk("fill_req_drop", 32'(sdram_req), 32'd0);
        data_rdy = 1'b1; sdram_din = d; tick; data_rdy = 1'b0; #1;
        chk("fill_ok", 32'(data_ok), 32'd1);
        chk("fill_dout", 32'(dout), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; cs = 1'b0; sdram_ack = 1'b0; data_rdy = 1'b0;
        addr = 18'h0; sdram_din = 16'h0;
        tick; tick;
        rst = 1'b0; #1;
        chk("rst_ok", 32'(data_ok), 32'd0);
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'h0);

        // Cold miss then hit
        fill(18'h00123, 16'hA5C3);
        chk("cold_addr_val", 32'(sdram_addr), 32'h10123);
        cs = 1'b0; tick;
        cs = 1'b1; addr = 18'h00123; #1;
        chk("hit_ok", 32'(data_ok), 32'd1);
        chk("hit_dout", 32'(dout), 32'hA5C3);
        tick;
        chk("hit_noreq", 32'(sdram_req), 32'd0);

        // Replacement from a clean cache: 1->e0, 2->e1, 3->e0 evicts 1
        cs = 1'b0; clr = 1'b1; tick; clr = 1'b0;
        fill(18'h1, 16'h1111);
        fill(18'h2, 16'h2222);
        fill(18'h3, 16'h3333);
        addr = 18'h2; #1;
        chk("repl_hit2", 32'(data_ok), 32'd1);
        chk("repl_dout2", 32'(dout), 32'h2222);
        addr = 18'h3; #1;
        chk("repl_hit3", 32'(data_ok), 32'd1);
        addr = 18'h1; #1;
        chk("repl_miss1", 32'(data_ok), 32'd0);
        tick;
        chk("repl_rereq", 32'(sdram_req), 32'd1);
        chk("repl_readdr", 32'(sdram_addr), 32'h10001);
        sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
        data_rdy = 1'b1; sdram_din = 16'h1112; tick; data_rdy = 1'b0;

        // Address change while waiting for data
        cs = 1'b0; clr = 1'b1; tick; clr = 1'b0;
        cs = 1'b1; addr = 18'h40; tick;
        chk("chg_addr40", 32'(sdram_addr), 32'h10040);
        sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
        addr = 18'h41; #1;
        chk("chg_ok_wait", 32'(data_ok), 32'd0);
        data_rdy = 1'b1; sdram_din = 16'h4040; tick; data_rdy = 1'b0; #1;
        chk("chg_ok_after", 32'(data_ok), 32'd0);
        tick;
        chk("chg_req41", 32'(sdram_req), 32'd1);
        chk("chg_addr41", 32'(sdram_addr), 32'h10041);
        sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
        data_rdy = 1'b1; sdram_din = 16'h4141; tick; data_rdy = 1'b0; #1;
        chk("chg_ok41", 32'(data_ok), 32'd1);
        chk("chg_dout41", 32'(dout), 32'h4141);
        addr = 18'h40; #1;
        chk("chg_hit40", 32'(data_ok), 32'd1);
        chk("chg_dout40", 32'(dout), 32'h4040);

        // clr coincident with data_rdy discards the fill
        addr = 18'h55; tick;
        sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
        data_rdy = 1'b1; clr = 1'b1; sdram_din = 16'h5555; tick;
        data_rdy = 1'b0; clr = 1'b0; #1;
        chk("clr_ok55", 32'(data_ok), 32'd0);
        addr = 18'h40; #1;
        chk("clr_inval40", 32'(data_ok), 32'd0);
        addr = 18'h55; tick;
        chk("clr_rereq", 32'(sdram_req), 32'd1);
        chk("clr_readdr", 32'(sdram_addr), 32'h10055);
        sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
        data_rdy = 1'b1; sdram_din = 16'h5556; tick; data_rdy = 1'b0; #1;
        chk("clr_fill_ok", 32'(data_ok), 32'd1);
        chk("clr_fill_dout", 32'(dout), 32'h5556);

        // Reset in WAIT; late data_rdy ignored
        addr = 18'h77; tick;
        sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
        rst = 1'b1; tick; rst = 1'b0; cs = 1'b0; #1;
        chk("rstw_req", 32'(sdram_req), 32'd0);
        data_rdy = 1'b1; sdram_din = 16'h7777; tick; data_rdy = 1'b0;
        cs = 1'b1; addr = 18'h77; #1;
        chk("rstw_ok77", 32'(data_ok), 32'd0);
        addr = 18'h55; #1;
        chk("rstw_ok55", 32'(data_ok), 32'd0);

        // clr beats a miss in IDLE
        addr = 18'h77; clr = 1'b1; tick; clr = 1'b0; #1;
        chk("clrwin_noreq", 32'(sdram_req), 32'd0);
        tick;
        chk("clrwin_req", 32'(sdram_req), 32'd1);
        chk("clrwin_addr", 32'(sdram_addr), 32'h10077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jtcontra_romrq.md
JTCONTRA_ROMRQ -- requirements
Module: jtcontra_romrq

Interface
REQ-001 Parameter AW, default 18: requester word-address width.
REQ-002 Parameter OFFSET, default 22'h0: SDRAM word base added to every requester address.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clr  input  1  cache invalidate strobe, one cycle.
REQ-006 addr  input  AW  requester word address (gfx rom_addr).
REQ-007 cs  input  1  requester read request, held until data_ok (gfx rom_cs).
REQ-008 dout  output  16  read data to requester (gfx rom_data).
REQ-009 data_ok  output  1  dout valid for current addr (gfx rom_ok).
REQ-010 sdram_req  output  1  SDRAM read request.
REQ-011 sdram_addr  output  22  SDRAM word address.
REQ-012 sdram_ack  input  1  SDRAM controller accepted request.
REQ-013 data_rdy  input  1  one-cycle strobe, sdram_din valid.
REQ-014 sdram_din  input  16  SDRAM read data.

Function
REQ-015 Cache: two entries, each valid bit, AW-bit tag, 16-bit data; 1-bit replace pointer selects next entry to fill.
REQ-016 Hit = any valid entry with tag == addr; evaluated combinationally on current addr.
REQ-017 data_ok = cs & hit, combinational; it never reflects a previous address, so an addr change with cs held and no hit drops data_ok in the same cycle.
REQ-018 dout = data of the hitting entry, entry 0 first if both hit; otherwise dout holds entry 0 data (don't-care to requester).
REQ-019 FSM states IDLE, REQ, WAIT.
- IDLE -> REQ when cs & ~hit & ~clr; latch addr into req_addr.
- REQ: sdram_req = 1; -> WAIT on sdram_ack; sdram_req = 0 from the cycle after ack.
- WAIT -> IDLE on data_rdy; write entry[ptr] = {1, req_addr, sdram_din}; toggle ptr.
REQ-020 sdram_addr = OFFSET + zero-extended req_addr, modulo 2^22; registered, stable from REQ entry until return to IDLE.
REQ-021 Hit latency: 0 cycles (data_ok with cs). Miss latency: data_ok the cycle after data_rdy when cs and addr unchanged.
REQ-022 cs dropped or addr changed in REQ/WAIT: transaction completes and fills normally; a new miss starts only after IDLE.
REQ-023 Request for the address being filled, in REQ/WAIT: no second SDRAM request; data_ok follows the fill.
REQ-024 clr: all valid bits cleared next cycle; ptr to 0; in-flight transaction continues but its data is discarded (no write), including when clr coincides with data_rdy.
REQ-025 clr in IDLE with cs & miss: clr wins, FSM stays IDLE that cycle.
REQ-026 data_rdy outside WAIT and sdram_ack outside REQ are ignored.
REQ-027 At most one outstanding SDRAM transaction at any time.

Reset
REQ-028 rst: state IDLE, sdram_req 0, sdram_addr 0, all valid bits 0, ptr 0, discard-pending flag 0; hence data_ok 0.
REQ-029 rst mid-transaction aborts it; a later data_rdy is ignored (REQ-026).
REQ-030 rst has priority over clr and all other inputs.

Verification
REQ-031 Cold miss: OFFSET=22'h10000, cs=1, addr=18'h00123 -> sdram_req=1 with sdram_addr=22'h10123; ack, then data_rdy with 16'hA5C3 -> next cycle data_ok=1, dout=16'hA5C3.
REQ-032 Hit: after REQ-031, cs low then high with addr 18'h00123 -> data_ok=1 same cycle, sdram_req stays 0.
REQ-033 Replacement: fill 18'h1, 18'h2, then 18'h3 -> 18'h1 evicted (entry 0); 18'h2 and 18'h3 hit; 18'h1 re-requests SDRAM.
REQ-034 Addr change mid-fill: miss on 18'h40, switch addr to 18'h41 while in WAIT -> data_ok=0 throughout; 18'h40 fills; then new request with sdram_addr=OFFSET+18'h41.
REQ-035 clr coincident with data_rdy -> entry not written, all valid=0; held cs re-issues sdram_req next IDLE.
REQ-036 rst asserted in WAIT, then data_rdy -> no entry written, data_ok=0, sdram_req=0.
